// File: rtl/move_unit.sv
// move_unit: pipelined register-move unit for the MIPS datapath.
// Handles MOVE, MFHI, MFLO, MTHI and MTLO, and owns the HI/LO pair, which the
// multiplier/divider can also load. A single registered output entry sits
// behind valid/ready handshakes on both sides.
// Build option: define MOVE_UNIT_COND_EN to add MOVZ/MOVN (ops 5/6). Without
// it those ops are flagged illegal exactly like the reserved op 7.
module move_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   rs,
   input  logic [WIDTH-1:0]   rt,
   input  logic [TAG_W-1:0]   tag_in,
   input  logic               prod_load,
   input  logic [2*WIDTH-1:0] prod,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               wr_en,
   output logic [TAG_W-1:0]   tag_out,
   output logic               illegal,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   typedef enum logic [2:0] {
      OP_MOVE = 3'd0,
      OP_MFHI = 3'd1,
      OP_MFLO = 3'd2,
      OP_MTHI = 3'd3,
      OP_MTLO = 3'd4,
      OP_MOVZ = 3'd5,
      OP_MOVN = 3'd6,
      OP_RSVD = 3'd7
   } op_t;

   logic             accept;
   logic [WIDTH-1:0] nxt_result;
   logic             nxt_wr_en;
   logic             nxt_illegal;
   logic             set_hi;
   logic             set_lo;

   // The slot can take a new op whenever it is empty or being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

`ifdef MOVE_UNIT_COND_EN
   logic rt_zero;
   assign rt_zero = (rt == '0);
`else
   logic unused_rt;
   assign unused_rt = ^rt;
`endif

   // Decode the presented op into the entry it would load and any HI/LO write.
   always_comb begin
      nxt_result  = '0;
      nxt_wr_en   = 1'b0;
      nxt_illegal = 1'b0;
      set_hi      = 1'b0;
      set_lo      = 1'b0;
      case (op)
         OP_MOVE: begin
            nxt_result = rs;
            nxt_wr_en  = 1'b1;
         end
         OP_MFHI: begin
            nxt_result = hi;
            nxt_wr_en  = 1'b1;
         end
         OP_MFLO: begin
            nxt_result = lo;
            nxt_wr_en  = 1'b1;
         end
         OP_MTHI: set_hi = 1'b1;
         OP_MTLO: set_lo = 1'b1;
`ifdef MOVE_UNIT_COND_EN
         OP_MOVZ: begin
            nxt_result = rs;
            nxt_wr_en  = rt_zero;
         end
         OP_MOVN: begin
            nxt_result = rs;
            nxt_wr_en  = !rt_zero;
         end
`endif
         default: nxt_illegal = 1'b1;
      endcase
   end

   // Output entry: load on accept, empty on drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         wr_en     <= 1'b0;
         tag_out   <= '0;
         illegal   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= nxt_result;
         wr_en     <= nxt_wr_en;
         tag_out   <= tag_in;
         illegal   <= nxt_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // HI/LO: an accepted MTHI/MTLO beats a product load for its own half only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (accept && set_hi)
            hi <= rs;
         else if (prod_load)
            hi <= prod[2*WIDTH-1:WIDTH];
         if (accept && set_lo)
            lo <= rs;
         else if (prod_load)
            lo <= prod[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_move_unit.sv
// Directed bench for move_unit: a vector table of single ops issued back to
// back, then hand-written sequences for HI/LO contention, backpressure and
// asynchronous reset.
module tb_move_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [4:0]  tag_in;
   logic        prod_load;
   logic [63:0] prod;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        wr_en;
   logic [4:0]  tag_out;
   logic        illegal;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   move_unit #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs(rs), .rt(rt), .tag_in(tag_in), .prod_load(prod_load),
      .prod(prod), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .wr_en(wr_en), .tag_out(tag_out), .illegal(illegal),
      .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  tag;
      logic [31:0] e_result;
      logic        e_wr_en;
      logic        e_illegal;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; rs = '0; rt = '0; tag_in = '0;
      prod_load = 1'b0; prod = '0; out_ready = 1'b1;

      vecs[0]  = '{3'd0, 32'hDEADBEEF, 32'h0, 5'd9,  32'hDEADBEEF, 1'b1, 1'b0};
      vecs[1]  = '{3'd3, 32'h12345678, 32'h0, 5'd1,  32'h0,        1'b0, 1'b0};
      vecs[2]  = '{3'd1, 32'h0,        32'h0, 5'd2,  32'h12345678, 1'b1, 1'b0};
      vecs[3]  = '{3'd4, 32'h0000ABCD, 32'h0, 5'd3,  32'h0,        1'b0, 1'b0};
      vecs[4]  = '{3'd2, 32'h0,        32'h0, 5'd4,  32'h0000ABCD, 1'b1, 1'b0};
`ifdef MOVE_UNIT_COND_EN
      vecs[5]  = '{3'd5, 32'h7,        32'h0, 5'd5,  32'h7,        1'b1, 1'b0};
      vecs[6]  = '{3'd6, 32'h7,        32'h0, 5'd6,  32'h7,        1'b0, 1'b0};
      vecs[7]  = '{3'd5, 32'h7,        32'h3, 5'd7,  32'h7,        1'b0, 1'b0};
      vecs[8]  = '{3'd6, 32'h9,        32'h3, 5'd8,  32'h9,        1'b1, 1'b0};
`else
      vecs[5]  = '{3'd5, 32'h7,        32'h0, 5'd5,  32'h0,        1'b0, 1'b1};
      vecs[6]  = '{3'd6, 32'h7,        32'h0, 5'd6,  32'h0,        1'b0, 1'b1};
      vecs[7]  = '{3'd5, 32'h7,        32'h3, 5'd7,  32'h0,        1'b0, 1'b1};
      vecs[8]  = '{3'd6, 32'h9,        32'h3, 5'd8,  32'h0,        1'b0, 1'b1};
`endif
      vecs[9]  = '{3'd7, 32'h55,       32'h0, 5'd10, 32'h0,        1'b0, 1'b1};
      vecs[10] = '{3'd0, 32'h0,        32'h0, 5'd31, 32'h0,        1'b1, 1'b0};

      // reset state
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result),    64'd0);
      check("rst_wr_en",     64'(wr_en),     64'd0);
      check("rst_tag_out",   64'(tag_out),   64'd0);
      check("rst_illegal",   64'(illegal),   64'd0);
      check("rst_hi",        64'(hi),        64'd0);
      check("rst_lo",        64'(lo),        64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      tick();
      rst_n = 1'b1;

      // vector table, issued back to back with out_ready held high
      for (int i = 0; i < NVEC; i++) begin
         in_valid = 1'b1;
         op = vecs[i].op; rs = vecs[i].rs; rt = vecs[i].rt; tag_in = vecs[i].tag;
         tick();
         check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("v%0d_result", i),    64'(result),    64'(vecs[i].e_result));
         check($sformatf("v%0d_wr_en", i),     64'(wr_en),     64'(vecs[i].e_wr_en));
         check($sformatf("v%0d_tag", i),       64'(tag_out),   64'(vecs[i].tag));
         check($sformatf("v%0d_illegal", i),   64'(illegal),   64'(vecs[i].e_illegal));
      end
      check("tbl_hi", 64'(hi), 64'h12345678);
      check("tbl_lo", 64'(lo), 64'h0000ABCD);
      in_valid = 1'b0;
      tick();
      check("drain_out_valid", 64'(out_valid), 64'd0);

      // product load alone
      prod_load = 1'b1; prod = 64'h00000011_00000022;
      tick();
      prod_load = 1'b0;
      check("prod_hi", 64'(hi), 64'h11);
      check("prod_lo", 64'(lo), 64'h22);
      check("prod_no_entry", 64'(out_valid), 64'd0);

      // MTLO races product load: LO from rs, HI from product
      in_valid = 1'b1; op = 3'd4; rs = 32'h5; tag_in = 5'd0;
      prod_load = 1'b1; prod = 64'h0000000A_0000000B;
      tick();
      in_valid = 1'b0; prod_load = 1'b0;
      check("mtlo_prod_hi", 64'(hi), 64'hA);
      check("mtlo_prod_lo", 64'(lo), 64'h5);
      check("mtlo_wr_en",   64'(wr_en), 64'd0);

      // MTHI races product load: HI from rs, LO from product
      in_valid = 1'b1; op = 3'd3; rs = 32'h77;
      prod_load = 1'b1; prod = 64'h00000033_00000044;
      tick();
      in_valid = 1'b0; prod_load = 1'b0;
      check("mthi_prod_hi", 64'(hi), 64'h77);
      check("mthi_prod_lo", 64'(lo), 64'h44);
      tick();

      // backpressure: entry holds, in_ready drops, drain+accept in one edge
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd0; rs = 32'h1; tag_in = 5'd12;
      tick();
      check("bp_first_valid",  64'(out_valid), 64'd1);
      check("bp_first_result", 64'(result),    64'h1);
      rs = 32'h2; tag_in = 5'd13;
      #1;
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      tick();
      check("bp_hold_valid",  64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result),    64'h1);
      check("bp_hold_tag",    64'(tag_out),   64'd12);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_high", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("bp_second_valid",  64'(out_valid), 64'd1);
      check("bp_second_result", 64'(result),    64'h2);
      check("bp_second_tag",    64'(tag_out),   64'd13);
      tick();
      check("bp_empty", 64'(out_valid), 64'd0);

      // asynchronous reset with a pending entry and HI=0xFF
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd3; rs = 32'hFF;
      tick();
      in_valid = 1'b0;
      check("ar_pre_valid", 64'(out_valid), 64'd1);
      check("ar_pre_hi",    64'(hi),        64'hFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", 64'(out_valid), 64'd0);
      check("ar_hi",        64'(hi),        64'd0);
      in_valid = 1'b1; op = 3'd0; rs = 32'h99; out_ready = 1'b1;
      tick();
      check("ar_no_accept", 64'(out_valid), 64'd0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      check("ar_after_valid", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
